des_key_mix: RTL and testbench

- Upstream neighbour of the eight DES S-box lookups in the round datapath.
- Takes the 32-bit right half R and the 48-bit round subkey K, applies the DES E expansion, XORs with K, and presents the 48-bit result as eight 6-bit S-box inputs.
- Registered stage with valid/ready handshakes on both sides and a 2-entry elastic buffer, so back-pressure from the substitution stage never drops a word.

---
 rtl/des_key_mix.sv | 135 +++++++++++++
 tb/tb_des_key_mix.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_mix.sv
// des_key_mix: DES round key-mixing stage, E(R) XOR K, ahead of the S-boxes.
//
// The 32-bit right half is expanded to 48 bits with the DES E table and
// XORed with the round subkey. The result is registered in a 2-entry elastic
// buffer with a head entry and a skid entry. Back-pressure from the
// substitution stage therefore never drops a word. in_ready is a registered
// signal and has no combinational path from out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   r_in[31:0]            right half, r_in[31] = DES bit 1
//   k_in[47:0]            subkey,     k_in[47] = DES bit 1
//   tag_in[TAG_W-1:0]     sideband tag (round index), passed through unchanged
//   out_valid / out_ready downstream handshake
//   sbox_in[47:0]         E(R)^K. [47:42] feeds S1 ... [5:0] feeds S8
//   tag_out[TAG_W-1:0]    tag of the word on sbox_in
//
// Optional build macro KEYMIX_ZEROIZE_EN adds input zeroize (synchronous,
// active-high). While it is high at a clock edge, all storage is cleared,
// pending push/pop are discarded, and in_ready reads 0 for that cycle.
module des_key_mix #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      r_in,
  input  logic [47:0]      k_in,
  input  logic [TAG_W-1:0] tag_in,
`ifdef KEYMIX_ZEROIZE_EN
  input  logic             zeroize,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      sbox_in,
  output logic [TAG_W-1:0] tag_out
);

  // Each 6-bit group g covers DES bits 4g..4g+5, wrapping 0->32 and 33->1.
  // rr prepends DES bit 32 and appends DES bit 1. Each group is then a
  // contiguous 6-bit window stepping down by 4.
  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [33:0] rr;
    rr = {r[0], r, r[31]};
    return {rr[33:28], rr[29:24], rr[25:20], rr[21:16],
            rr[17:12], rr[13:8],  rr[9:4],   rr[5:0]};
  endfunction

  logic [47:0]      mix_p0;
  logic [47:0]      head_p1, skid_p1;
  logic [TAG_W-1:0] head_tag_p1, skid_tag_p1;
  logic [1:0]       count_p1, count_nxt;
  logic             rdy_p1;
  logic             push, pop;

  // Stage 0: combinational expansion and key mix on the input side.
  assign mix_p0 = e_expand(r_in) ^ k_in;

`ifdef KEYMIX_ZEROIZE_EN
  assign in_ready = rdy_p1 & ~zeroize;
`else
  assign in_ready = rdy_p1;
`endif

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count_p1 != 2'd0);
  assign sbox_in   = head_p1;
  assign tag_out   = head_tag_p1;

  always_comb begin
    count_nxt = count_p1;
    case ({push, pop})
      2'b10:   count_nxt = count_p1 + 2'd1;
      2'b01:   count_nxt = count_p1 - 2'd1;
      default: count_nxt = count_p1;
    endcase
  end

  // Stage 1: elastic buffer storage. Outputs always show the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1    <= 2'd0;
      rdy_p1      <= 1'b1;
      head_p1     <= '0;
      skid_p1     <= '0;
      head_tag_p1 <= '0;
      skid_tag_p1 <= '0;
    end
`ifdef KEYMIX_ZEROIZE_EN
    else if (zeroize) begin
      count_p1    <= 2'd0;
      rdy_p1      <= 1'b1;
      head_p1     <= '0;
      skid_p1     <= '0;
      head_tag_p1 <= '0;
      skid_tag_p1 <= '0;
    end
`endif
    else begin
      count_p1 <= count_nxt;
      rdy_p1   <= (count_nxt != 2'd2);
      case ({push, pop})
        2'b10: begin
          // The first word lands in head. A second word waits in skid.
          if (count_p1 == 2'd0) begin
            head_p1     <= mix_p0;
            head_tag_p1 <= tag_in;
          end else begin
            skid_p1     <= mix_p0;
            skid_tag_p1 <= tag_in;
          end
        end
        2'b01: begin
          // When the last word is popped, head keeps its value. This way an
          // empty buffer shows the last popped word, never X.
          if (count_p1 == 2'd2) begin
            head_p1     <= skid_p1;
            head_tag_p1 <= skid_tag_p1;
          end
        end
        2'b11: begin
          // Push and pop together only happen at count 1. The new word
          // replaces the departing head.
          head_p1     <= mix_p0;
          head_tag_p1 <= tag_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_mix.sv
module tb_des_key_mix;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      r_in;
  logic [47:0]      k_in;
  logic [TAG_W-1:0] tag_in;
`ifdef KEYMIX_ZEROIZE_EN
  logic             zeroize;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [47:0]      sbox_in;
  logic [TAG_W-1:0] tag_out;

  always #5 clk = ~clk;

  des_key_mix #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .k_in      (k_in),
    .tag_in    (tag_in),
`ifdef KEYMIX_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sbox_in   (sbox_in),
    .tag_out   (tag_out)
  );

  typedef struct packed {
    logic [47:0]      s;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_pops  = 0;
  int   stall_cnt = 0;
  int   cyc = 0;
  bit   rand_done;

  // DES E table: output position i (1..48) takes R bit e_tab[i-1].
  int e_tab [48] = '{32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,
                      8, 9,10,11,12,13,  12,13,14,15,16,17,
                     16,17,18,19,20,21,  20,21,22,23,24,25,
                     24,25,26,27,28,29,  28,29,30,31,32, 1};

  function automatic logic [47:0] ref_mix(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic        b;
    x = '0;
    for (int i = 0; i < 48; i++) begin
      // DES bit n sits at r[32-n]. Shift it down to bit 0.
      b = 1'((r >> (32 - e_tab[i])) & 32'd1);
      x = {x[46:0], b};
    end
    return x ^ k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard: pop on every output transfer, then record accepted inputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got sbox 0x%0h tag %0d, expected no word", sbox_in, tag_out);
      end else begin
        e = exp_q.pop_front();
        check("out_sbox", {16'h0, sbox_in}, {16'h0, e.s});
        check("out_tag", 64'(tag_out), 64'(e.t));
        n_pops++;
      end
    end
    if (rst_n === 1'b1 && in_valid && in_ready)
      exp_q.push_back({ref_mix(r_in, k_in), tag_in});
  end

  // Call just after a posedge. Returns just after the edge that accepted the word.
  task automatic send(input logic [31:0] r, input logic [47:0] k, input logic [TAG_W-1:0] t);
    int w;
    w = 0;
    r_in = r; k_in = k; tag_in = t; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      stall_cnt++; w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_expect(input string name, input logic [31:0] r, input logic [47:0] k,
                             input logic [47:0] exp_s);
    out_ready = 1'b1;
    send(r, k, 4'd5);
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check(name, {16'h0, sbox_in}, {16'h0, exp_s});
    @(posedge clk); #1;
  endtask

  initial begin
    int p0, c0, w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    r_in = '0; k_in = '0; tag_in = '0;
`ifdef KEYMIX_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sbox", {16'h0, sbox_in}, 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference vector
    out_ready = 1'b1;
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd1);
    @(negedge clk);
    check("ref_valid", 64'(out_valid), 64'd1);
    check("ref_sbox", {16'h0, sbox_in}, 64'h6117BA866527);
    check("ref_s3", 64'(sbox_in[35:30]), 64'h1E);
    check("ref_tag", 64'(tag_out), 64'd1);
    @(posedge clk); #1;

    // Expansion edge bits
    send_expect("edge_bit1", 32'h80000000, 48'h0, 48'h400000000001);
    send_expect("edge_bit32", 32'h00000001, 48'h0, 48'h800000000002);
    send_expect("edge_key", 32'h0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF);

    // Back-pressure: two words fill the buffer, the third is held off
    out_ready = 1'b0;
    p0 = n_pops;
    send($urandom, {$urandom, 16'($urandom)}, 4'd1);
    send($urandom, {$urandom, 16'($urandom)}, 4'd2);
    r_in = $urandom; k_in = {$urandom, 16'($urandom)}; tag_in = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head_tag", 64'(tag_out), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      r_in = $urandom; k_in = {$urandom, 16'($urandom)};
    end
    @(negedge clk);
    check("bp_still_full", 64'(in_ready), 64'd0);
    check("bp_held_tag", 64'(tag_out), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin w++; @(negedge clk); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_pops", 64'(n_pops - p0), 64'd3);

    // Streaming: 16 back-to-back words, one per cycle
    out_ready = 1'b1;
    stall_cnt = 0;
    p0 = n_pops;
    c0 = cyc;
    for (int t = 0; t < 16; t++)
      send($urandom, {$urandom, 16'($urandom)}, 4'(t));
    check("stream_cycles", 64'(cyc - c0), 64'd16);
    check("stream_stalls", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    check("stream_pops", 64'(n_pops - p0), 64'd16);

    // Reset mid-operation with two words buffered
    out_ready = 1'b0;
    send($urandom, {$urandom, 16'($urandom)}, 4'd9);
    send($urandom, {$urandom, 16'($urandom)}, 4'd10);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_sbox", {16'h0, sbox_in}, 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    check("mrst_tag", 64'(tag_out), 64'd0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mrst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send($urandom, {$urandom, 16'($urandom)}, 4'd11);
    @(posedge clk); #1;

`ifdef KEYMIX_ZEROIZE_EN
    // Zeroize with a full buffer and a word offered
    out_ready = 1'b0;
    send($urandom, {$urandom, 16'($urandom)}, 4'd12);
    send($urandom, {$urandom, 16'($urandom)}, 4'd13);
    r_in = $urandom; k_in = {$urandom, 16'($urandom)}; tag_in = 4'd7;
    in_valid = 1'b1; zeroize = 1'b1;
    @(negedge clk);
    check("zz_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    zeroize = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("zz_out_valid", 64'(out_valid), 64'd0);
    check("zz_sbox", {16'h0, sbox_in}, 64'd0);
    check("zz_tag", 64'(tag_out), 64'd0);
    check("zz_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif

    // Random traffic with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send($urandom, {$urandom, 16'($urandom)}, 4'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin @(posedge clk); #1; w++; end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no completion, expected finish before 400000");
    $fatal(1);
  end

endmodule
